// File: rtl/ssp_fifo_pkg.sv
// Shared constants, width helper and parameter-legality check for the SSP FIFO.
package ssp_fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef struct packed {
        int unsigned ptr_w;
        int unsigned lvl_w;
    } fifo_widths_t;

    // Encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic fifo_widths_t fifo_widths(input int unsigned depth);
        fifo_widths_t w;
        w.ptr_w = $clog2(depth);
        w.lvl_w = $clog2(depth + 1);
        return w;
    endfunction

    function automatic bit fifo_params_ok(input int unsigned depth, input int unsigned thresh);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module ssp_fifo_mem #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; valid contents are tracked by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ssp_param_fifo.sv
// Parametrised synchronous SSP FIFO with level, almost-full interrupt and sticky error flags.
// Define SSP_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module ssp_param_fifo
    import ssp_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned AFULL_THRESH = DEPTH
) (
    input  logic                       pclk,
    input  logic                       clear,
    input  logic                       en,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rvalid,
    output logic                       nempty,
    output logic                       full,
    output logic                       intr,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf,
    output logic                       udf,
    input  logic                       err_clr
);

    localparam fifo_widths_t W     = fifo_widths(DEPTH);
    localparam int unsigned  PTR_W = W.ptr_w;
    localparam int unsigned  LVL_W = W.lvl_w;

    if (!fifo_params_ok(DEPTH, AFULL_THRESH)) begin : g_param_check
        $error("ssp_param_fifo: DEPTH must be a power of 2 >= 2 and AFULL_THRESH in 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             nempty_q, full_q, intr_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] mem_rdata;
    fifo_op_e         op;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        rd_acc   = en && rd && nempty_q;
        // A full FIFO can still take a write when a read frees a slot in the same cycle.
        wr_acc   = en && wr && (!full_q || rd_acc);
        op       = fifo_op_e'({wr_acc, rd_acc});
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case (op)
            OP_WR:   level_d = level_q + LVL_W'(1);
            OP_RD:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Clear first so a rejected operation in the same cycle keeps its flag set.
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (en && err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (en && wr && !wr_acc) ovf_d = 1'b1;
        if (en && rd && !rd_acc) udf_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            nempty_q <= 1'b0;
            full_q   <= 1'b0;
            intr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            nempty_q <= (level_d != '0);
            full_q   <= (level_d == LVL_W'(DEPTH));
            intr_q   <= (level_d >= LVL_W'(AFULL_THRESH));
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    ssp_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i   (pclk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

`ifdef SSP_FIFO_FWFT_EN
    // Head word is visible as soon as it is stored; rd only acknowledges the pop.
    assign rdata  = nempty_q ? mem_rdata : '0;
    assign rvalid = nempty_q;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge pclk or negedge clear) begin
        if (!clear) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign nempty = nempty_q;
    assign full   = full_q;
    assign intr   = intr_q;
    assign level  = level_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: tb/tb_ssp_param_fifo.sv
// Self-checking bench for ssp_param_fifo (WIDTH=8, DEPTH=4, AFULL_THRESH=3) against a queue model.
module tb_ssp_param_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic       pclk;
    logic       clear;
    logic       en, wr, rd, err_clr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, nempty, full, intr, ovf, udf;
    logic [2:0] level;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: the FIFO contents as a plain queue plus the two sticky flags.
    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_rvalid;
    logic [7:0] m_rdata;

    ssp_param_fifo #(
        .WIDTH        (8),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .pclk    (pclk),
        .clear   (clear),
        .en      (en),
        .wr      (wr),
        .wdata   (wdata),
        .rd      (rd),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .nempty  (nempty),
        .full    (full),
        .intr    (intr),
        .level   (level),
        .ovf     (ovf),
        .udf     (udf),
        .err_clr (err_clr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    function automatic logic [16:0] dut_vec();
        return {rvalid, nempty, full, intr, ovf, udf, level, rdata};
    endfunction

    function automatic logic [16:0] model_vec();
        logic       rv;
        logic [7:0] rdv;
`ifdef SSP_FIFO_FWFT_EN
        rv  = (q.size() != 0);
        rdv = rv ? q[0] : 8'h00;
`else
        rv  = m_rvalid;
        rdv = m_rdata;
`endif
        return {rv, q.size() != 0, q.size() == DEPTH, q.size() >= AFULL,
                m_ovf, m_udf, 3'(q.size()), rdv};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 8'h00;
    endtask

    task automatic do_reset();
        en = 0; wr = 0; rd = 0; err_clr = 0; wdata = 8'h00;
        clear = 1'b0;
        @(posedge pclk);
        #1;
        clear = 1'b1;
        model_reset();
    endtask

    // Drive one cycle, advance the model by the same edge, then settle 1 time unit past the edge.
    task automatic step(input bit e, input bit w, input bit r, input bit c, input logic [7:0] d);
        bit rd_ok, wr_ok;
        en = e; wr = w; rd = r; err_clr = c; wdata = d;
        @(posedge pclk);
        rd_ok = e && r && (q.size() != 0);
        wr_ok = e && w && ((q.size() < DEPTH) || rd_ok);
        m_rvalid = 1'b0;
        if (rd_ok) begin
            m_rdata  = q.pop_front();
            m_rvalid = 1'b1;
        end
        if (wr_ok) q.push_back(d);
        if (e && c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (e && w && !wr_ok) m_ovf = 1'b1;
        if (e && r && !rd_ok) m_udf = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (dut_vec() !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 17'h0);
        end
        step(1, 0, 1, 0, 8'h00);
        tests_run++;
        if (udf !== 1'b1 || rvalid !== 1'b0 || rdata !== 8'h00 || level !== 3'd0) begin
            tests_failed++;
            $display("FAIL empty_read: udf=%b rvalid=%b rdata=%h level=%0d expected 1 0 00 0",
                     udf, rvalid, rdata, level);
        end
        step(1, 0, 0, 1, 8'h00);
        tests_run++;
        if (udf !== 1'b0 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL err_clr_udf: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp [4] = '{8'h63, 8'h61, 8'h74, 8'h73};
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, exp[i]);
            tests_run++;
            if (level !== 3'(i + 1) || intr !== (i >= 2) || full !== (i == 3) ||
                dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL fill[%0d]: level=%0d intr=%b full=%b got %h expected %h",
                         i, level, intr, full, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
`ifdef SSP_FIFO_FWFT_EN
            tests_run++;
            if (rdata !== exp[i] || rvalid !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_head[%0d]: rdata=%h rvalid=%b expected %h 1", i, rdata, rvalid, exp[i]);
            end
`endif
            step(1, 0, 1, 0, 8'h00);
`ifndef SSP_FIFO_FWFT_EN
            tests_run++;
            if (rdata !== exp[i] || rvalid !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_data[%0d]: rdata=%h rvalid=%b expected %h 1", i, rdata, rvalid, exp[i]);
            end
`endif
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL drain_state[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        step(1, 0, 0, 0, 8'h00);
        tests_run++;
        if (nempty !== 1'b0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drained_empty: nempty=%b rvalid=%b expected 0 0", nempty, rvalid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] fill [4] = '{8'h63, 8'h61, 8'h74, 8'h73};
        logic [7:0] exp  [4] = '{8'h61, 8'h74, 8'h73, 8'h69};
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, fill[i]);
        step(1, 1, 0, 0, 8'h62);
        tests_run++;
        if (ovf !== 1'b1 || level !== 3'd4) begin
            tests_failed++;
            $display("FAIL ovf_set: ovf=%b level=%0d expected 1 4", ovf, level);
        end
        step(1, 1, 1, 0, 8'h69);
        tests_run++;
        if (ovf !== 1'b1 || level !== 3'd4 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL full_rdwr: got %h expected %h", dut_vec(), model_vec());
        end
        // Clear and a new overflow in the same cycle: the overflow must win.
        step(1, 1, 0, 1, 8'h55);
        tests_run++;
        if (ovf !== 1'b1 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL err_wins: got %h expected %h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) begin
`ifdef SSP_FIFO_FWFT_EN
            tests_run++;
            if (rdata !== exp[i]) begin
                tests_failed++;
                $display("FAIL ovf_drain[%0d]: rdata=%h expected %h", i, rdata, exp[i]);
            end
`endif
            step(1, 0, 1, 0, 8'h00);
`ifndef SSP_FIFO_FWFT_EN
            tests_run++;
            if (rdata !== exp[i]) begin
                tests_failed++;
                $display("FAIL ovf_drain[%0d]: rdata=%h expected %h", i, rdata, exp[i]);
            end
`endif
        end
        step(1, 0, 0, 1, 8'h00);
        tests_run++;
        if (ovf !== 1'b0 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL ovf_clr: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, 8'(i));
            tests_run++;
            if (level > 3'd1 || dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL wrap_wr[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
            step(1, 0, 1, 0, 8'h00);
            tests_run++;
            if (ovf !== 1'b0 || udf !== 1'b0 || level !== 3'd0 || dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL wrap_rd[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
`ifndef SSP_FIFO_FWFT_EN
            tests_run++;
            if (rdata !== 8'(i)) begin
                tests_failed++;
                $display("FAIL wrap_data[%0d]: rdata=%h expected %h", i, rdata, 8'(i));
            end
`endif
        end
    endtask

    task automatic test_empty_rdwr();
        do_reset();
        step(1, 1, 1, 0, 8'h77);
        tests_run++;
        if (udf !== 1'b1 || level !== 3'd1 || dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL empty_rdwr: got %h expected %h", dut_vec(), model_vec());
        end
        step(1, 0, 0, 1, 8'h00);
    endtask

    task automatic test_enable_and_clear();
        do_reset();
        step(1, 1, 0, 0, 8'hA5);
        step(1, 1, 0, 0, 8'h5A);
        step(1, 1, 0, 0, 8'hC3);
        step(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 8'hFF);
            tests_run++;
            if (level !== 3'd2 || rvalid !== (nempty & `ifdef SSP_FIFO_FWFT_EN 1'b1 `else 1'b0 `endif) ||
                dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL en_low[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        step(1, 0, 1, 0, 8'h00);
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL en_resume: got %h expected %h", dut_vec(), model_vec());
        end
        en = 0; wr = 0; rd = 0; err_clr = 0;
        step(1, 1, 0, 0, 8'h3C);
        #3;
        clear = 1'b0;
        #1;
        tests_run++;
        if (dut_vec() !== 17'h0) begin
            tests_failed++;
            $display("FAIL async_clear: got %h expected %h", dut_vec(), 17'h0);
        end
        model_reset();
        #1;
        clear = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                 $urandom_range(0, 15) == 0, 8'($urandom));
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

`ifdef SSP_FIFO_FWFT_EN
    task automatic test_fwft();
        do_reset();
        step(1, 1, 0, 0, 8'h41);
        tests_run++;
        if (rdata !== 8'h41 || rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwft_show: rdata=%h rvalid=%b expected 41 1", rdata, rvalid);
        end
        step(1, 0, 1, 0, 8'h00);
        tests_run++;
        if (nempty !== 1'b0 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwft_pop: nempty=%b rvalid=%b expected 0 0", nempty, rvalid);
        end
    endtask
`endif

    initial begin
        clear = 1'b0;
        en = 0; wr = 0; rd = 0; err_clr = 0; wdata = 8'h00;
        model_reset();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_empty_rdwr();
        test_enable_and_clear();
        test_random();
`ifdef SSP_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ssp_param_fifo.md
Name: ssp_param_fifo

Overview:
Parametrised synchronous FIFO that replaces the fixed 8-bit, 4-entry SSP buffer. It has:
- independent read and write strobes, with a simultaneous read+write in the same cycle;
- a programmable almost-full interrupt;
- an occupancy count;
- sticky overflow and underflow flags.

It sits between the SSP shift logic and the APB-side register interface, one instance per direction (TX, RX).

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 4: number of entries; must be a power of 2 and at least 2.
- AFULL_THRESH, DEPTH: intr asserts when level is at least this value (1..DEPTH).

Ports:
- pclk  input  1  clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-low reset.
- en  input  1  active-high enable; when low, wr, rd and err_clr are ignored and all state holds.
- wr  input  1  write request for this cycle.
- wdata  input  WIDTH  word to write when wr is accepted.
- rd  input  1  read request for this cycle.
- rdata  output  WIDTH  word read out.
- rvalid  output  1  pulses high for one cycle while rdata holds a freshly read word.
- nempty  output  1  high when level is not 0.
- full  output  1  high when level equals DEPTH.
- intr  output  1  high when level is at least AFULL_THRESH.
- level  output  $clog2(DEPTH+1)  current occupancy.
- ovf  output  1  sticky; set by a write rejected because the FIFO is full.
- udf  output  1  sticky; set by a read rejected because the FIFO is empty.
- err_clr  input  1  synchronous clear of ovf and udf (gated by en).

Behaviour:
- Reset (clear low, asynchronous):
  - wr_ptr, rd_ptr, level, rdata, rvalid, nempty, full, intr, ovf and udf all go to 0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits wide, wrap modulo DEPTH, and advance by 1 on each accepted operation.
- Write is accepted when en && wr && (!full || read accepted this cycle):
  - mem[wr_ptr] is loaded from wdata.
- Read is accepted when en && rd && nempty:
  - Default (registered) mode: rdata takes mem[rd_ptr] and rvalid is 1 in the following cycle, i.e. 1-cycle latency.
  - rvalid is 0 in every cycle that did not follow an accepted read.
  - rdata holds its last value when no read is accepted.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Status outputs:
  - nempty, full and intr are registered, updated in the same edge as level, and are consistent with level in every cycle.
- Boundary cases:
  - Full with rd+wr: both accepted, level stays DEPTH, ovf is not set.
  - Full with wr only: write dropped, ovf is set to 1, contents unchanged.
  - Empty with rd+wr (registered mode): read rejected and udf set; write accepted; level becomes 1.
  - Empty with rd only: udf is set, rvalid stays 0, rdata unchanged.
  - ovf and udf stay set until err_clr or reset. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
  - en low: no pointer, level or flag change, and rvalid drops to 0.
  - Reset mid-operation: all content is discarded and outputs return to their reset values immediately.

Optional Feature:
- Macro: SSP_FIFO_FWFT_EN (first-word-fall-through).
- With the macro defined:
  - rdata is combinationally mem[rd_ptr] whenever nempty.
  - rvalid equals nempty (level, not pulse).
  - rd acts as a pop acknowledge.
  - Empty with rd+wr: read still rejected and udf set, because the word is not yet visible.
- Without the macro: registered 1-cycle read as described in Behaviour.

Decomposition:
- Package ssp_fifo_pkg holds:
  - a function returning pointer and level widths from DEPTH;
  - default WIDTH and DEPTH constants;
  - a parameter-legality check: DEPTH a power of 2, AFULL_THRESH in range.
- Sub-module ssp_fifo_mem: a WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port.
- Top level holds pointers, level, flags and the FWFT/registered output mux.

Test Plan (WIDTH=8, DEPTH=4, AFULL_THRESH=3 unless noted):
1. Reset, then rd with en=1 on an empty FIFO -> udf=1, rvalid=0, rdata=0x00, level=0; err_clr pulse -> udf=0.
2. Write 0x63, 0x61, 0x74, 0x73 -> level 1,2,3,4; intr rises on the 3rd write; full=1 after the 4th. Then 4 reads -> rdata 0x63, 0x61, 0x74, 0x73, each with a 1-cycle rvalid pulse; nempty=0 at the end.
3. Full FIFO, wr 0x62 -> ovf=1, level=4. Then rd+wr 0x69 in one cycle -> level=4, ovf unchanged. Drain -> order 0x61, 0x74, 0x73, 0x69.
4. Wrap-around: 10 alternating write/read pairs with data 0x00..0x09 -> reads return identical data in order, level never exceeds 1, no flags set.
5. Mid-sequence: en=0 with wr=1, rd=1 for 3 cycles -> level and pointers unchanged. Then assert clear low asynchronously between edges -> all outputs 0 before the next pclk edge.
6. Compile with SSP_FIFO_FWFT_EN: write 0x41 -> rdata=0x41 and rvalid=1 in the cycle after the write edge; rd -> nempty=0, rvalid=0.
